if_redirect_sequencer: RTL and testbench
========================================

# if_redirect_sequencer

Fetch-redirect controller for the IF stage. It arbitrates the four redirect sources: trap, mret, resolved branch, and branch prediction. It drives a single redirect PC into the PC controller. It then sequences the flush and holdoff window that the C-extension state, instruction aligner and PC controller consume after every control-flow change. It also adds the extra holdoff cycle that a halfword-aligned target needs before its fetch word is valid.

## Interface
- XLEN, 32, PC/target width
- i_clk  in  1  clock
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clk
- i_stall  in  1  pipeline stall
- i_trap_taken / i_trap_target  in  1 / XLEN  trap redirect request and target
- i_mret_taken / i_mret_target  in  1 / XLEN  mret redirect request and target
- i_branch_taken / i_branch_target  in  1 / XLEN  resolved-mispredict redirect request and target
- i_predict_taken / i_predict_target  in  1 / XLEN  front-end prediction request and target
- o_redirect_valid  out  1  redirect accepted this cycle (combinational)
- o_redirect_pc  out  XLEN  accepted target, bit 0 forced 0; all-zero when invalid
- o_redirect_src  out  2  winning source (redirect_src_e)
- o_flush  out  1  registered; 2-cycle flush window after a backend redirect
- o_control_flow_holdoff  out  1  registered; first cycle after a backend redirect
- o_prediction_holdoff  out  1  registered; first cycle after an accepted prediction
- o_any_holdoff_safe  out  1  OR of registered holdoffs, including halfword holdoff; built from flops only
- o_halfword_target  out  1  registered; extra holdoff cycle for a target with bit 1 set
- o_busy  out  1  state != IDLE

## Operation
- Priority: trap > mret > branch > predict. Only the winner is reported.
- Backend sources (trap, mret, branch):
  - Accepted in any state, regardless of i_stall.
  - Latest accepted redirect wins: a new one in any non-IDLE state restarts at FLUSH_A with the new target.
- Prediction:
  - Accepted only when state == IDLE, !i_stall, and no backend request is present.
  - Otherwise it is dropped, and o_redirect_valid is 0 for it.
- The target is latched in tgt_q on acceptance. tgt_q[1] selects the HALF state.
- States: IDLE, FLUSH_A, FLUSH_B, PRED_HOLD, HALF.
  - IDLE: backend accept -> FLUSH_A; prediction accept -> PRED_HOLD.
  - FLUSH_A -> FLUSH_B unconditionally; not gated by stall.
  - FLUSH_B -> HALF if tgt_q[1], else IDLE; not gated by stall.
  - PRED_HOLD -> HALF if tgt_q[1], else IDLE; holds while i_stall.
  - HALF -> IDLE; holds while i_stall.
- A backend accept in any state overrides the state transitions above and goes to FLUSH_A.
- Output decode (all from state flops):
  - o_flush = FLUSH_A | FLUSH_B
  - o_control_flow_holdoff = FLUSH_A
  - o_prediction_holdoff = PRED_HOLD
  - o_halfword_target = HALF
  - o_any_holdoff_safe = FLUSH_A | PRED_HOLD | HALF
- Reset: state IDLE, tgt_q 0, all registered outputs 0. A reset in mid-sequence aborts it, with no pending redirect retained. The combinational outputs are 0 while i_reset is asserted.

## Timing
- Backend redirect accepted in cycle N:
  - N: o_redirect_valid=1.
  - N+1: o_flush=1, o_control_flow_holdoff=1, o_any_holdoff_safe=1.
  - N+2: o_flush=1; the other holdoffs are 0.
  - N+3: o_halfword_target=1 and o_any_holdoff_safe=1 if the target has bit 1 set; otherwise IDLE.
- Prediction accepted in cycle N:
  - N+1: o_prediction_holdoff=1 (extended while stalled).
  - N+2: HALF if the target has bit 1 set.
- Redirect latency: 0 cycles. The next accepted prediction comes no earlier than the cycle after returning to IDLE.
- There is no combinational path from i_stall or the *_taken inputs to o_flush or any holdoff output.

## Structure
- riscv_pkg additions:
  - redirect_src_e with values TRAP=0, MRET=1, BRANCH=2, PRED=3.
  - redirect_state_e covering the five states.
- Sub-module: redirect_priority_arb. It is a purely combinational 4-way fixed-priority select that outputs valid, src and target with bit 0 cleared. The prediction enable is an input to it.
- The sequencer flops (state, tgt_q) and output decode live in if_redirect_sequencer.

## Test plan
- Branch to 0x0000_1000 in IDLE:
  - N: valid=1, pc=0x1000, src=BRANCH.
  - N+1, N+2: o_flush=1; o_control_flow_holdoff=1 at N+1 only.
  - N+3: IDLE, all outputs 0.
- Trap to 0x0000_0102 together with branch to 0x2000 and predict to 0x3000 in the same cycle:
  - pc=0x102, src=TRAP.
  - Flush for 2 cycles, then o_halfword_target=1 for 1 cycle, then IDLE.
- Branch to 0x400, then mret to 0x800 during FLUSH_B:
  - Second accept gives pc=0x800.
  - Flush is extended: o_flush is high for 4 consecutive cycles in total.
- Prediction to 0x0000_0206 with i_stall raised the next cycle for 3 cycles:
  - o_prediction_holdoff holds for 4 cycles.
  - Then HALF for 1 cycle, then IDLE.
  - A prediction presented during PRED_HOLD is ignored (valid=0).
- Prediction with i_stall=1 in IDLE -> valid=0, state stays IDLE.
- Reset asserted in FLUSH_A -> next cycle all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the IF-stage redirect sequencer
package riscv_pkg;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {
      SRC_TRAP   = 2'd0,
      SRC_MRET   = 2'd1,
      SRC_BRANCH = 2'd2,
      SRC_PRED   = 2'd3
   } redirect_src_e;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH_A,
      ST_FLUSH_B,
      ST_PRED_HOLD,
      ST_HALF
   } redirect_state_e;
endpackage

// File: rtl/if_redirect_sequencer_arb.sv
// redirect_priority_arb: combinational trap > mret > branch > predict select
module redirect_priority_arb
   import riscv_pkg::*;
(
   input  logic            trap_taken,
   input  logic [XLEN-1:0] trap_target,
   input  logic            mret_taken,
   input  logic [XLEN-1:0] mret_target,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   input  logic            predict_taken,
   input  logic [XLEN-1:0] predict_target,
   input  logic            pred_en,
   output logic            valid,
   output logic            backend,
   output redirect_src_e   src,
   output logic [XLEN-1:0] target
);
   logic            pred_v;
   logic [XLEN-1:0] raw;
   always_comb begin
      pred_v  = predict_taken & pred_en;
      backend = trap_taken | mret_taken | branch_taken;
      valid   = backend | pred_v;
      src     = trap_taken ? SRC_TRAP : mret_taken ? SRC_MRET :
                branch_taken ? SRC_BRANCH : pred_v ? SRC_PRED : SRC_TRAP;
      raw     = trap_taken ? trap_target : mret_target;
      raw     = (trap_taken | mret_taken) ? raw : branch_taken ? branch_target : predict_target;
      target  = valid ? (raw & ~XLEN'(1)) : '0;
   end
endmodule

// File: rtl/if_redirect_sequencer.sv
// if_redirect_sequencer: arbitrates fetch redirects and sequences flush/holdoff windows
module if_redirect_sequencer
   import riscv_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_stall,
   input  logic            i_trap_taken,
   input  logic [XLEN-1:0] i_trap_target,
   input  logic            i_mret_taken,
   input  logic [XLEN-1:0] i_mret_target,
   input  logic            i_branch_taken,
   input  logic [XLEN-1:0] i_branch_target,
   input  logic            i_predict_taken,
   input  logic [XLEN-1:0] i_predict_target,
   output logic            o_redirect_valid,
   output logic [XLEN-1:0] o_redirect_pc,
   output redirect_src_e   o_redirect_src,
   output logic            o_flush,
   output logic            o_control_flow_holdoff,
   output logic            o_prediction_holdoff,
   output logic            o_any_holdoff_safe,
   output logic            o_halfword_target,
   output logic            o_busy
);
   redirect_state_e state_q;
   logic [1:1]      tgt_q;
   logic            arb_valid, arb_backend, pred_en, backend_acc, pred_acc;
   redirect_src_e   arb_src;
   logic [XLEN-1:0] arb_pc;

   assign pred_en = (state_q == ST_IDLE) & ~i_stall & ~i_reset;

   redirect_priority_arb u_arb (
      .trap_taken    (i_trap_taken),
      .trap_target   (i_trap_target),
      .mret_taken    (i_mret_taken),
      .mret_target   (i_mret_target),
      .branch_taken  (i_branch_taken),
      .branch_target (i_branch_target),
      .predict_taken (i_predict_taken),
      .predict_target(i_predict_target),
      .pred_en       (pred_en),
      .valid         (arb_valid),
      .backend       (arb_backend),
      .src           (arb_src),
      .target        (arb_pc)
   );

   assign backend_acc      = arb_backend & ~i_reset;
   assign pred_acc         = arb_valid & ~arb_backend & ~i_reset;
   assign o_redirect_valid = arb_valid & ~i_reset;
   assign o_redirect_pc    = i_reset ? '0 : arb_pc;
   assign o_redirect_src   = i_reset ? SRC_TRAP : arb_src;

   // Only the halfword bit of the accepted target steers the sequence
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
      end else if (backend_acc || pred_acc) begin
         state_q <= backend_acc ? ST_FLUSH_A : ST_PRED_HOLD;
         tgt_q   <= arb_pc[1];
      end else begin
         case (state_q)
            ST_FLUSH_A:   state_q <= ST_FLUSH_B;
            ST_FLUSH_B:   state_q <= tgt_q[1] ? ST_HALF : ST_IDLE;
            ST_PRED_HOLD: state_q <= i_stall ? ST_PRED_HOLD : tgt_q[1] ? ST_HALF : ST_IDLE;
            ST_HALF:      state_q <= i_stall ? ST_HALF : ST_IDLE;
            default:      state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_flush                = (state_q == ST_FLUSH_A) | (state_q == ST_FLUSH_B);
   assign o_control_flow_holdoff = state_q == ST_FLUSH_A;
   assign o_prediction_holdoff   = state_q == ST_PRED_HOLD;
   assign o_halfword_target      = state_q == ST_HALF;
   assign o_any_holdoff_safe     = (state_q == ST_FLUSH_A) | (state_q == ST_PRED_HOLD) | (state_q == ST_HALF);
   assign o_busy                 = state_q != ST_IDLE;
endmodule

// File: tb/tb_if_redirect_sequencer.sv
// tb_if_redirect_sequencer: per-cycle vector table plus a repeated-trap flush sequence
module tb_if_redirect_sequencer;
   import riscv_pkg::*;
   logic            i_clk = 1'b0, i_reset = 1'b1, i_stall = 1'b0;
   logic            i_trap_taken = 1'b0, i_mret_taken = 1'b0, i_branch_taken = 1'b0, i_predict_taken = 1'b0;
   logic [XLEN-1:0] i_trap_target = '0, i_mret_target = '0, i_branch_target = '0, i_predict_target = '0;
   logic            o_redirect_valid, o_flush, o_control_flow_holdoff, o_prediction_holdoff;
   logic            o_any_holdoff_safe, o_halfword_target, o_busy;
   logic [XLEN-1:0] o_redirect_pc;
   redirect_src_e   o_redirect_src;

   if_redirect_sequencer dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_stall(i_stall),
      .i_trap_taken(i_trap_taken), .i_trap_target(i_trap_target),
      .i_mret_taken(i_mret_taken), .i_mret_target(i_mret_target),
      .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
      .i_predict_taken(i_predict_taken), .i_predict_target(i_predict_target),
      .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc), .o_redirect_src(o_redirect_src),
      .o_flush(o_flush), .o_control_flow_holdoff(o_control_flow_holdoff),
      .o_prediction_holdoff(o_prediction_holdoff), .o_any_holdoff_safe(o_any_holdoff_safe),
      .o_halfword_target(o_halfword_target), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   // o = {flush, cf_holdoff, pred_holdoff, halfword, any_holdoff, busy}
   typedef struct {
      logic        rst, stall;
      logic [3:0]  tk;
      logic [31:0] tt, mt, bt, pt;
      logic        v;
      logic [31:0] pc;
      logic [1:0]  src;
      logic [5:0]  o;
   } vec_t;
   vec_t vq[$];
   int checks = 0, fails = 0;

   task automatic add(input logic rst, stall, input logic [3:0] tk, input logic [31:0] tt, mt, bt, pt,
                      input logic v, input logic [31:0] pc, input logic [1:0] src, input logic [5:0] o);
      vq.push_back('{rst, stall, tk, tt, mt, bt, pt, v, pc, src, o});
   endtask

   task automatic chk(input string name, input int idx, input logic [63:0] act, exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   localparam logic [5:0] I = 6'b000000, FA = 6'b110011, FB = 6'b100001, PH = 6'b001011, HF = 6'b000111;

   initial begin
      // branch to 0x1000
      add(0,0,4'b0010, 0,0,32'h1000,0,        1,32'h1000,2'd2, I);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, FA);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, FB);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, I);
      // trap + branch + predict together, halfword target
      add(0,0,4'b1011, 32'h102,0,32'h2000,32'h3000, 1,32'h102,2'd0, I);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, FA);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, FB);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, HF);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, I);
      // branch then mret in FLUSH_B
      add(0,0,4'b0010, 0,0,32'h400,0,         1,32'h400,2'd2, I);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, FA);
      add(0,0,4'b0100, 0,32'h800,0,0,         1,32'h800,2'd1, FB);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, FA);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, FB);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, I);
      // prediction to 0x206 with a 3-cycle stall, second prediction ignored
      add(0,0,4'b0001, 0,0,0,32'h206,         1,32'h206,2'd3, I);
      add(0,1,4'b0001, 0,0,0,32'h500,         0,0,0, PH);
      add(0,1,4'b0000, 0,0,0,0,               0,0,0, PH);
      add(0,1,4'b0000, 0,0,0,0,               0,0,0, PH);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, PH);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, HF);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, I);
      // stalled prediction in IDLE dropped
      add(0,1,4'b0001, 0,0,0,32'h600,         0,0,0, I);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, I);
      // reset in FLUSH_A aborts
      add(0,0,4'b1000, 32'h900,0,0,0,         1,32'h900,2'd0, I);
      add(1,0,4'b0010, 0,0,32'ha00,0,         0,0,0, FA);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, I);
      // HALF holds under stall
      add(0,0,4'b0001, 0,0,0,32'h10a,         1,32'h10a,2'd3, I);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, PH);
      add(0,1,4'b0000, 0,0,0,0,               0,0,0, HF);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, HF);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, I);
      // branch overrides stalled PRED_HOLD; flush ignores stall; bit 0 cleared
      add(0,0,4'b0001, 0,0,0,32'h1000,        1,32'h1000,2'd3, I);
      add(0,1,4'b0010, 0,0,32'hc03,0,         1,32'hc02,2'd2, PH);
      add(0,1,4'b0000, 0,0,0,0,               0,0,0, FA);
      add(0,1,4'b0000, 0,0,0,0,               0,0,0, FB);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, HF);
      add(0,0,4'b0000, 0,0,0,0,               0,0,0, I);

      repeat (2) @(negedge i_clk);
      foreach (vq[k]) begin
         @(negedge i_clk);
         i_reset = vq[k].rst; i_stall = vq[k].stall;
         {i_trap_taken, i_mret_taken, i_branch_taken, i_predict_taken} = vq[k].tk;
         i_trap_target = vq[k].tt; i_mret_target = vq[k].mt;
         i_branch_target = vq[k].bt; i_predict_target = vq[k].pt;
         #1;
         chk("valid", k, 64'(o_redirect_valid), 64'(vq[k].v));
         chk("pc_src", k, 64'({o_redirect_pc, o_redirect_src}), 64'({vq[k].pc, vq[k].src}));
         chk("regs", k, 64'({o_flush, o_control_flow_holdoff, o_prediction_holdoff,
                             o_halfword_target, o_any_holdoff_safe, o_busy}), 64'(vq[k].o));
      end

      // traps on three consecutive cycles: flush window stretches to four cycles
      begin
         int cnt = 0;
         for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            i_reset = 0; i_stall = 0;
            {i_mret_taken, i_branch_taken, i_predict_taken} = '0;
            i_trap_taken = c < 3; i_trap_target = 32'h40;
            #1;
            if (o_flush) cnt++;
         end
         chk("flush_len", 0, 64'(cnt), 64'd4);
         chk("final_idle", 0, 64'(o_busy), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
